// File: rtl/gc_refresh_scheduler_if.sv
// Handshake bundle between the refresh scheduler and its controller/wrappers.
// The master drives enable, clr_err and ref_done; the scheduler is the slave.
interface gc_refresh_scheduler_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int CNT_W     = 16
);
  logic                 enable;
  logic                 clr_err;
  logic [NUM_BANKS-1:0] ref_done;
  logic [NUM_BANKS-1:0] start_sr;
  logic [NUM_BANKS-1:0] ref_en_current;
  logic [NUM_BANKS-1:0] ref_en_old;
  logic [BANK_W-1:0]    cur_bank;
  logic                 busy;
  logic                 overrun;
  logic                 timeout_err;
  logic [CNT_W-1:0]     ref_count;

  modport master (
    output enable, clr_err, ref_done,
    input  start_sr, ref_en_current, ref_en_old,
    input  cur_bank, busy, overrun, timeout_err, ref_count
  );

  modport slave (
    input  enable, clr_err, ref_done,
    output start_sr, ref_en_current, ref_en_old,
    output cur_bank, busy, overrun, timeout_err, ref_count
  );
endinterface

// File: rtl/gc_refresh_scheduler.sv
// Round-robin background refresh sequencer for gain-cell memory banks,
// paced by a retention-interval timer with sticky overrun/timeout flags.
module gc_refresh_scheduler #(
  parameter int NUM_BANKS    = 4,
  parameter int BANK_W       = 2,
  parameter int REF_INTERVAL = 1024,
  parameter int TIMEOUT      = 512,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst,
  gc_refresh_scheduler_if.slave bus
);
  localparam int IV_W = $clog2(REF_INTERVAL);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [IV_W-1:0] IV_LAST = IV_W'(REF_INTERVAL - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [BANK_W-1:0] B_LAST = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_NEXT,
    S_ERR
  } state_t;

  state_t               r_state;
  logic [IV_W-1:0]      r_ivl;
  logic [TO_W-1:0]      r_tcnt;
  logic                 r_pending;
  logic [BANK_W-1:0]    r_bank;
  logic [NUM_BANKS-1:0] r_start_sr;
  logic [NUM_BANKS-1:0] r_en_cur;
  logic [NUM_BANKS-1:0] r_en_old;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 r_timeout_err;
  logic [CNT_W-1:0]     r_count;

  logic                 w_tick;
  logic                 w_consume;
  logic                 w_ovr_evt;
  logic                 w_done;
  logic                 w_to;
  logic [BANK_W-1:0]    w_prev;
  logic [NUM_BANKS-1:0] w_cur_oh;
  logic [NUM_BANKS-1:0] w_old_oh;

  always_comb begin
    w_tick    = (r_ivl == '0);
    w_consume = (r_state == S_IDLE) && bus.enable && r_pending;
    // A tick landing on the consuming cycle refills pending, not an overrun
    w_ovr_evt = w_tick && r_pending && !w_consume;
    w_done    = bus.ref_done[r_bank];
    w_to      = (r_tcnt == TO_LAST);
    w_prev    = (r_bank == '0) ? B_LAST : r_bank - 1'b1;
    w_cur_oh  = NUM_BANKS'(1) << r_bank;
    w_old_oh  = NUM_BANKS'(1) << w_prev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_ivl         <= IV_LAST;
      r_tcnt        <= '0;
      r_pending     <= 1'b0;
      r_bank        <= '0;
      r_start_sr    <= '0;
      r_en_cur      <= '0;
      r_en_old      <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_count       <= '0;
    end else begin
      r_ivl <= w_tick ? IV_LAST : r_ivl - 1'b1;

      if (w_tick) begin
        r_pending <= 1'b1;
      end else if (w_consume) begin
        r_pending <= 1'b0;
      end

      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_overrun <= 1'b0;
      end

      if (bus.clr_err) begin
        r_timeout_err <= 1'b0;
      end

      r_start_sr <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (w_consume) begin
            r_state    <= S_KICK;
            r_start_sr <= w_cur_oh;
            r_en_cur   <= w_cur_oh;
            r_en_old   <= w_old_oh;
            r_busy     <= 1'b1;
          end
        end
        S_KICK: begin
          r_state <= S_WAIT;
          r_tcnt  <= '0;
        end
        S_WAIT: begin
          if (w_done) begin
            r_state  <= S_NEXT;
            r_en_cur <= '0;
            r_en_old <= '0;
          end else if (w_to) begin
            r_state       <= S_ERR;
            r_en_cur      <= '0;
            r_en_old      <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_NEXT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_count <= r_count + 1'b1;
          r_bank  <= (r_bank == B_LAST) ? '0 : r_bank + 1'b1;
        end
        S_ERR: begin
          if (bus.clr_err) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.start_sr       = r_start_sr;
  assign bus.ref_en_current = r_en_cur;
  assign bus.ref_en_old     = r_en_old;
  assign bus.cur_bank       = r_bank;
  assign bus.busy           = r_busy;
  assign bus.overrun        = r_overrun;
  assign bus.timeout_err    = r_timeout_err;
  assign bus.ref_count      = r_count;
endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Directed bench for gc_refresh_scheduler: vector table for the round-robin
// sweep plus hand sequences for timeout, overrun, spurious done and reset.
module tb_gc_refresh_scheduler;
  logic clk;
  logic rst;

  gc_refresh_scheduler_if #(
    .NUM_BANKS(4), .BANK_W(2), .CNT_W(16)
  ) bus ();

  gc_refresh_scheduler #(
    .NUM_BANKS(4), .BANK_W(2), .REF_INTERVAL(16),
    .TIMEOUT(8), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    int         dly;
    logic [3:0] start;
    logic [3:0] old;
    logic [1:0] bank;
    logic [1:0] nbank;
    int         cnt;
    int         gap;
  } vec_t;

  vec_t vecs[5];

  int checks;
  int failures;
  int cyc_n;
  int last_kick;
  int prev_kick;
  int rel;
  int K;
  int done_dly;
  bit auto_done;
  int rd_cnt;
  logic [3:0] rd_mask;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample point is 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (auto_done) begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        bus.ref_done = (rd_cnt == 0) ? rd_mask : 4'b0000;
      end else begin
        bus.ref_done = 4'b0000;
      end
      if (bus.start_sr != 4'b0000) begin
        rd_cnt  = done_dly;
        rd_mask = bus.start_sr;
      end
    end
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (bus.start_sr != 4'b0000) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      failures++;
      checks++;
      $display("FAIL kick_wait: no start_sr within %0d cycles", budget);
    end
    last_kick = cyc_n;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3, 4'b0001, 4'b1000, 2'd0, 2'd1, 1, 17};
    vecs[1] = '{1'b1, 3, 4'b0010, 4'b0001, 2'd1, 2'd2, 2, 16};
    vecs[2] = '{1'b1, 3, 4'b0100, 4'b0010, 2'd2, 2'd3, 3, 16};
    vecs[3] = '{1'b1, 3, 4'b1000, 4'b0100, 2'd3, 2'd0, 4, 16};
    vecs[4] = '{1'b1, 3, 4'b0001, 4'b1000, 2'd0, 2'd1, 5, 16};

    checks    = 0;
    failures  = 0;
    cyc_n     = 0;
    rd_cnt    = 0;
    rd_mask   = 4'b0000;
    done_dly  = 3;
    auto_done = 1'b1;
    rst          = 1'b0;
    bus.enable   = 1'b0;
    bus.clr_err  = 1'b0;
    bus.ref_done = 4'b0000;

    cyc();
    cyc();
    chk("reset_outputs",
        {bus.start_sr, bus.ref_en_current, bus.ref_en_old, bus.cur_bank,
         bus.busy, bus.overrun, bus.timeout_err, bus.ref_count}, 0);

    // Round-robin sweep driven by the vector table
    rst = 1'b1;
    rel = cyc_n;
    prev_kick = rel;
    for (int i = 0; i < 5; i++) begin
      bus.enable = vecs[i].en;
      done_dly   = vecs[i].dly;
      wait_start(40);
      chk($sformatf("v%0d_gap", i), last_kick - prev_kick, vecs[i].gap);
      prev_kick = last_kick;
      chk($sformatf("v%0d_start", i), bus.start_sr, vecs[i].start);
      chk($sformatf("v%0d_cur", i), bus.ref_en_current, vecs[i].start);
      chk($sformatf("v%0d_old", i), bus.ref_en_old, vecs[i].old);
      chk($sformatf("v%0d_bank", i), bus.cur_bank, vecs[i].bank);
      cyc();
      chk($sformatf("v%0d_wait", i),
          {bus.start_sr, bus.ref_en_current, bus.ref_en_old, bus.busy},
          {4'b0000, vecs[i].start, vecs[i].old, 1'b1});
      cyc();
      cyc();
      cyc();
      chk($sformatf("v%0d_next", i),
          {bus.ref_en_current, bus.ref_en_old, bus.busy},
          {4'b0000, 4'b0000, 1'b1});
      cyc();
      chk($sformatf("v%0d_idle", i),
          {bus.busy, bus.cur_bank, bus.ref_count},
          {1'b0, vecs[i].nbank, 16'(vecs[i].cnt)});
    end

    // Timeout into ERR, then retry the same bank
    auto_done    = 1'b0;
    bus.ref_done = 4'b0000;
    wait_start(40);
    chk("to_kick", bus.start_sr, 4'b0010);
    for (int i = 0; i < 8; i++) cyc();
    chk("to_wait8", {bus.busy, bus.timeout_err}, {1'b1, 1'b0});
    cyc();
    chk("to_err",
        {bus.timeout_err, bus.busy, bus.ref_en_current, bus.ref_en_old,
         bus.cur_bank, bus.ref_count},
        {1'b1, 1'b0, 4'b0000, 4'b0000, 2'd1, 16'd5});
    cyc();
    chk("to_err_hold", {bus.timeout_err, bus.busy}, {1'b1, 1'b0});
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("to_clr", bus.timeout_err, 1'b0);
    auto_done = 1'b1;
    wait_start(40);
    chk("to_retry", bus.start_sr, 4'b0010);
    K = last_kick;
    for (int i = 0; i < 5; i++) cyc();
    chk("to_retry_done", {bus.ref_count, bus.cur_bank}, {16'd6, 2'd2});

    // enable=0 across two ticks raises overrun
    bus.enable = 1'b0;
    while (cyc_n < K + 30) cyc();
    chk("ovr_before", {bus.overrun, bus.busy}, {1'b0, 1'b0});
    cyc();
    chk("ovr_set", bus.overrun, 1'b1);
    bus.enable = 1'b1;
    cyc();
    chk("ovr_kick", bus.start_sr, 4'b0100);
    for (int i = 0; i < 5; i++) cyc();
    chk("ovr_op_done", {bus.ref_count, bus.busy}, {16'd7, 1'b0});
    begin
      logic [3:0] extra;
      extra = 4'b0000;
      while (cyc_n < K + 46) begin
        cyc();
        extra = extra | bus.start_sr;
      end
      chk("ovr_single_op", extra, 4'b0000);
    end
    chk("ovr_sticky", bus.overrun, 1'b1);
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    chk("ovr_clr", {bus.overrun, bus.cur_bank}, {1'b0, 2'd3});

    // done during KICK and on a foreign bank are ignored
    auto_done    = 1'b0;
    bus.ref_done = 4'b1000;
    cyc();
    chk("sp_kick", bus.start_sr, 4'b1000);
    bus.ref_done = 4'b0001;
    cyc();
    chk("sp_wait1", {bus.busy, bus.ref_en_current}, {1'b1, 4'b1000});
    cyc();
    chk("sp_wait2", {bus.busy, bus.ref_en_current}, {1'b1, 4'b1000});
    bus.ref_done = 4'b1000;
    cyc();
    bus.ref_done = 4'b0000;
    chk("sp_next", {bus.busy, bus.ref_en_current}, {1'b1, 4'b0000});
    cyc();
    chk("sp_idle", {bus.ref_count, bus.cur_bank, bus.busy},
        {16'd8, 2'd0, 1'b0});

    // Asynchronous reset in the middle of WAIT
    wait_start(40);
    chk("rs_kick", bus.start_sr, 4'b0001);
    cyc();
    cyc();
    chk("rs_in_wait", {bus.busy, bus.ref_en_current}, {1'b1, 4'b0001});
    #2;
    rst = 1'b0;
    #1;
    chk("rs_async",
        {bus.start_sr, bus.ref_en_current, bus.ref_en_old, bus.cur_bank,
         bus.busy, bus.overrun, bus.timeout_err, bus.ref_count}, 0);
    auto_done = 1'b1;
    rd_cnt    = 0;
    cyc();
    rst = 1'b1;
    rel = cyc_n;
    wait_start(40);
    chk("rs_latency", last_kick - rel, 17);
    chk("rs_kick0", {bus.start_sr, bus.ref_en_old, bus.ref_count},
        {4'b0001, 4'b1000, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gc_refresh_scheduler.md
Name: gc_refresh_scheduler

Overview:
- Sequences background refresh across NUM_BANKS gain-cell memory wrappers.
- For each bank in turn, the block:
  - issues the one-cycle start_SR pulse to that bank;
  - holds ref_en_current on the bank being refreshed;
  - holds ref_en_old on its predecessor, which acts as the copy-of-interest bank;
  - waits for that bank's ref_done, then advances round-robin.
- A retention-interval timer paces refresh operations. Overrun and timeout conditions are reported as sticky flags.

Parameters:
- NUM_BANKS, 4: number of memory wrappers scheduled; must be ≥2.
- BANK_W, 2: width of the bank index; equals clog2(NUM_BANKS).
- REF_INTERVAL, 1024: cycles between refresh triggers; must be ≥4.
- TIMEOUT, 512: maximum cycles spent in WAIT before an error is raised.
- CNT_W, 16: width of the completed-refresh counter.

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: allows new refresh operations to start.
- clr_err, input, 1: clears overrun and timeout_err; exits ERR.
- ref_done, input, NUM_BANKS: per-bank refresh-done indications from the wrappers.
- start_sr, output, NUM_BANKS: one-hot, one-cycle SR reset pulse.
- ref_en_current, output, NUM_BANKS: one-hot; the bank being refreshed.
- ref_en_old, output, NUM_BANKS: one-hot; the predecessor (COI) bank.
- cur_bank, output, BANK_W: index of the bank next to be, or being, refreshed.
- busy, output, 1: high in KICK, WAIT and NEXT.
- overrun, output, 1: sticky; a trigger arrived while one was already pending.
- timeout_err, output, 1: sticky; WAIT exceeded TIMEOUT.
- ref_count, output, CNT_W: number of completed refreshes; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cur_bank=0, interval counter=REF_INTERVAL-1, pending=0.
  - All outputs 0.
- Interval timer:
  - Free-running down-counter; reloads REF_INTERVAL-1 after reaching 0. Runs regardless of enable or state.
  - The cycle after the count reaches 0, pending is set.
  - If pending is already 1 and not being consumed in that cycle, overrun is set to 1 (sticky).
- IDLE:
  - if enable && pending, go to KICK next cycle; pending is cleared on entry to KICK.
  - If a tick coincides with consumption, pending stays 1 and overrun is not set.
- KICK (exactly 1 cycle):
  - start_sr[cur_bank]=1.
  - ref_en_current[cur_bank]=1.
  - ref_en_old[(cur_bank-1) mod NUM_BANKS]=1; bank 0's predecessor is NUM_BANKS-1.
  - ref_done is ignored in KICK.
  - Next state is WAIT; the timeout counter is cleared.
- WAIT:
  - ref_en_current and ref_en_old are held as in KICK; start_sr=0.
  - Only ref_done[cur_bank] is sampled. When it is 1, go to NEXT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without done, go to ERR.
  - ref_done from other banks is ignored.
- NEXT (1 cycle):
  - Enables are deasserted and ref_count increments.
  - cur_bank advances by 1, wrapping from NUM_BANKS-1 to 0.
  - Go to IDLE. Back-to-back operation is therefore KICK, WAIT…, NEXT, IDLE, KICK, with at least 1 IDLE cycle between operations.
- ERR:
  - All enables 0, timeout_err=1, cur_bank not advanced, ref_count unchanged.
  - On clr_err=1, go to IDLE; the same bank is retried if pending.
- clr_err:
  - In any state, clears overrun and timeout_err next cycle.
  - If a new overrun event occurs in the same cycle, set wins.
- enable=0:
  - Does not abort KICK, WAIT or NEXT; the operation in progress completes.
  - Only blocks the IDLE→KICK transition; pending is retained.
- Mid-operation reset: asynchronous return to reset values; all enables drop immediately.
- Output encoding: all outputs are registered. At most one bit of each one-hot vector is set. ref_en_current and ref_en_old never select the same bank.

Test Plan (bench parameters REF_INTERVAL=16, NUM_BANKS=4, TIMEOUT=8):
1. Reset release, enable=1, ref_done responding 3 cycles after start_sr:
   - first start_sr=4'b0001 appears after the first interval tick;
   - ref_en_old=4'b1000 during that operation;
   - ref_count=1 and cur_bank=1 after NEXT.
2. Four consecutive intervals:
   - start_sr sequence is 0001, 0010, 0100, 1000, then 0001 again (cur_bank wraps 3→0);
   - ref_count=4 after the fourth NEXT.
3. ref_done held 0 for the bank in WAIT:
   - ERR after 8 WAIT cycles, timeout_err=1, enables 0, cur_bank unchanged;
   - clr_err then a tick: the same bank is re-kicked.
4. enable=0 across 2 interval ticks:
   - overrun=1 after the second tick;
   - enable=1 then starts exactly one operation;
   - clr_err clears overrun.
5. Spurious ref_done on a non-current bank, and ref_done[cur] asserted during KICK:
   - both ignored; WAIT continues until done is seen in WAIT.
6. rst asserted during WAIT:
   - all outputs 0 immediately;
   - after release, the next kick targets bank 0 with ref_count=0.
